// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : EX-stage ALU; single-cycle logic/arith ops, iterative 1-bit/cycle
//            shifter, valid/ready on both sides, registered result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [4:0]        shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              illegal,
    output logic              busy
);

    // ALU control encoding shared with alu_ctrl
    localparam logic [CTRL_W-1:0] c_OP_ADD   = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] c_OP_ADDI  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] c_OP_ADDIU = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] c_OP_LW    = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] c_OP_SW    = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] c_OP_SUB   = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] c_OP_BEQ   = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] c_OP_AND   = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] c_OP_OR    = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] c_OP_ORI   = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] c_OP_XOR   = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] c_OP_SLT   = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] c_OP_LUI   = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] c_OP_SLL   = CTRL_W'(13);
    localparam logic [CTRL_W-1:0] c_OP_SRL   = CTRL_W'(14);
    localparam logic [CTRL_W-1:0] c_OP_SRA   = CTRL_W'(15);
    localparam logic [CTRL_W-1:0] c_OP_SLLV  = CTRL_W'(16);
    localparam logic [CTRL_W-1:0] c_OP_SRLV  = CTRL_W'(17);
    localparam logic [CTRL_W-1:0] c_OP_SRAV  = CTRL_W'(18);

    localparam logic [1:0] c_SH_LL = 2'd0;
    localparam logic [1:0] c_SH_RL = 2'd1;
    localparam logic [1:0] c_SH_RA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state_q,  w_state_d;
    logic [DATA_W-1:0]   r_acc_q,    w_acc_d;
    logic [4:0]          r_cnt_q,    w_cnt_d;
    logic [1:0]          r_kind_q,   w_kind_d;
    logic [DATA_W-1:0]   r_result_q, w_result_d;
    logic                r_zero_q,   w_zero_d;
    logic                r_ovf_q,    w_ovf_d;
    logic                r_ill_q,    w_ill_d;

    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_op_res;
    logic                w_op_ovf;
    logic                w_op_ill;
    logic                w_op_shift;
    logic [1:0]          w_op_kind;
    logic [4:0]          w_op_amt;
    logic [DATA_W-1:0]   w_step;
    logic                w_in_ready;
    logic                w_accept;

    assign w_sum  = src_a + src_b;
    assign w_diff = src_a - src_b;

    // Operation decode; shift ops preload src_b so a zero amount completes at once
    always_comb begin
        w_op_res   = '0;
        w_op_ovf   = 1'b0;
        w_op_ill   = 1'b0;
        w_op_shift = 1'b0;
        w_op_kind  = c_SH_LL;
        w_op_amt   = shamt;
        case (alu_ctrl)
            c_OP_ADD, c_OP_ADDI: begin
                w_op_res = w_sum;
                w_op_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != src_a[DATA_W-1]);
            end
            c_OP_ADDIU, c_OP_LW, c_OP_SW: w_op_res = w_sum;
            c_OP_SUB, c_OP_BEQ: begin
                w_op_res = w_diff;
                w_op_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                           (w_diff[DATA_W-1] != src_a[DATA_W-1]);
            end
            c_OP_AND:          w_op_res = src_a & src_b;
            c_OP_OR, c_OP_ORI: w_op_res = src_a | src_b;
            c_OP_XOR:          w_op_res = src_a ^ src_b;
            c_OP_SLT:          w_op_res = {{(DATA_W-1){1'b0}},
                                           ($signed(src_a) < $signed(src_b))};
            c_OP_LUI:          w_op_res = {src_b[15:0], {(DATA_W-16){1'b0}}};
            c_OP_SLL, c_OP_SRL, c_OP_SRA,
            c_OP_SLLV, c_OP_SRLV, c_OP_SRAV: begin
                w_op_res   = src_b;
                w_op_shift = 1'b1;
                if (alu_ctrl == c_OP_SLLV || alu_ctrl == c_OP_SRLV ||
                    alu_ctrl == c_OP_SRAV) begin
                    w_op_amt = src_a[4:0];
                end
                if (alu_ctrl == c_OP_SRL || alu_ctrl == c_OP_SRLV) begin
                    w_op_kind = c_SH_RL;
                end else if (alu_ctrl == c_OP_SRA || alu_ctrl == c_OP_SRAV) begin
                    w_op_kind = c_SH_RA;
                end
            end
            default: w_op_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_step = {r_acc_q[DATA_W-2:0], 1'b0};
        case (r_kind_q)
            c_SH_RL: w_step = {1'b0, r_acc_q[DATA_W-1:1]};
            c_SH_RA: w_step = {r_acc_q[DATA_W-1], r_acc_q[DATA_W-1:1]};
            default: w_step = {r_acc_q[DATA_W-2:0], 1'b0};
        endcase
    end

    assign w_in_ready = ~rst & ((r_state_q == ST_IDLE) ||
                                ((r_state_q == ST_DONE) && out_ready));
    assign w_accept   = in_valid & w_in_ready;

    always_comb begin
        w_state_d  = r_state_q;
        w_acc_d    = r_acc_q;
        w_cnt_d    = r_cnt_q;
        w_kind_d   = r_kind_q;
        w_result_d = r_result_q;
        w_zero_d   = r_zero_q;
        w_ovf_d    = r_ovf_q;
        w_ill_d    = r_ill_q;
        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_op_shift && (w_op_amt != 5'd0)) begin
                        w_state_d = ST_SHIFT;
                        w_acc_d   = src_b;
                        w_cnt_d   = w_op_amt;
                        w_kind_d  = w_op_kind;
                    end else begin
                        w_state_d  = ST_DONE;
                        w_result_d = w_op_res;
                        w_zero_d   = (w_op_res == '0);
                        w_ovf_d    = w_op_ovf;
                        w_ill_d    = w_op_ill;
                    end
                end else if ((r_state_q == ST_DONE) && out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_acc_d = w_step;
                w_cnt_d = r_cnt_q - 5'd1;
                if (r_cnt_q == 5'd1) begin
                    w_state_d  = ST_DONE;
                    w_result_d = w_step;
                    w_zero_d   = (w_step == '0);
                    w_ovf_d    = 1'b0;
                    w_ill_d    = 1'b0;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_acc_q    <= '0;
            r_cnt_q    <= '0;
            r_kind_q   <= c_SH_LL;
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_ill_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_acc_q    <= w_acc_d;
            r_cnt_q    <= w_cnt_d;
            r_kind_q   <= w_kind_d;
            r_result_q <= w_result_d;
            r_zero_q   <= w_zero_d;
            r_ovf_q    <= w_ovf_d;
            r_ill_q    <= w_ill_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state_q == ST_DONE);
    assign busy      = (r_state_q != ST_IDLE);
    assign result    = r_result_q;
    assign zero      = r_zero_q;
    assign overflow  = r_ovf_q;
    assign illegal   = r_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed and random checks of alu_exec_unit against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_ADDI = 5'd1,  OP_ADDIU = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd5,  OP_BEQ  = 5'd6,  OP_OR    = 5'd8;
    localparam logic [4:0] OP_XOR = 5'd10, OP_SLT  = 5'd11, OP_LUI   = 5'd12;
    localparam logic [4:0] OP_SLL = 5'd13, OP_SRA  = 5'd15, OP_SRLV  = 5'd17;

    alu_exec_unit #(.CTRL_W(5), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .shamt    (shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model from the operation table, using wide signed arithmetic
    function automatic void ref_op(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   output logic [31:0] r, output logic o,
                                   output logic il, output int lat);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s  = sa + sb;
        longint d  = sa - sb;
        int n = 0;
        r = 32'h0; o = 1'b0; il = 1'b0; lat = 1;
        case (op)
            5'd0, 5'd1:       begin r = a + b; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'd2, 5'd3, 5'd4: r = a + b;
            5'd5, 5'd6:       begin r = a - b; o = (d > 64'sd2147483647) || (d < -64'sd2147483648); end
            5'd7:             r = a & b;
            5'd8, 5'd9:       r = a | b;
            5'd10:            r = a ^ b;
            5'd11:            r = (sa < sb) ? 32'd1 : 32'd0;
            5'd12:            r = b << 16;
            5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18: begin
                n = (op >= 5'd16) ? int'(a[4:0]) : int'(sh);
                if (op == 5'd13 || op == 5'd16)      r = b << n;
                else if (op == 5'd14 || op == 5'd17) r = b >> n;
                else                                 r = 32'($signed(b) >>> n);
                lat = (n > 0) ? n + 1 : 1;
            end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int stall);
        logic [31:0] er;
        logic eo, ei;
        int el;
        int lat;
        ref_op(op, a, b, sh, er, eo, ei, el);
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; alu_ctrl = op; src_a = a; src_b = b; shamt = sh;
        out_ready = (stall == 0);
        @(negedge clk);
        // scramble operands after accept; the op in flight must not see them
        in_valid = 1'b0; alu_ctrl = 5'($urandom); src_a = $urandom; src_b = $urandom;
        shamt = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_result"}, result, er);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, ei});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_held_result"}, result, er);
            chk({tag, "_held_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_held_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_released"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; src_a = '0; src_b = '0;
        shamt = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_ovf",   OP_ADD,   32'h7FFF_FFFF, 32'h1, 5'd0, 0);
        run_op("addiu",     OP_ADDIU, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
        run_op("sub_ovf",   OP_SUB,   32'h8000_0000, 32'h1, 5'd0, 0);
        run_op("beq_eq",    OP_BEQ,   32'h1234_5678, 32'h1234_5678, 5'd0, 0);
        run_op("slt_neg",   OP_SLT,   32'hFFFF_FFFF, 32'h1, 5'd0, 0);
        run_op("sra31",     OP_SRA,   32'h0, 32'h8000_0000, 5'd31, 0);
        run_op("sll0",      OP_SLL,   32'h0, 32'hDEAD_BEEF, 5'd0, 0);

        // back-to-back OR then LUI
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = OP_OR; src_a = 32'h0000_0F0F; src_b = 32'hF000_0001;
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_first_result", result, 32'hF000_0F0F);
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        alu_ctrl = OP_LUI; src_a = 32'h0; src_b = 32'h0000_ABCD;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_second_result", result, 32'hABCD_0000);
        @(negedge clk);
        chk("b2b_drained", {31'd0, out_valid}, 32'd0);

        run_op("bp_xor",    OP_XOR,   32'hA5A5_5A5A, 32'h0F0F_F0F0, 5'd0, 5);

        // reset while an SRLV is in its shift phase
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = OP_SRLV; src_a = 32'd16; src_b = 32'hFFFF_0000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_no_result", {31'd0, out_valid}, 32'd0);

        run_op("illegal",   5'd31,    32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 0);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 4) == 0) ra = rb;
            if ($urandom_range(0, 5) == 0) rb = 32'h8000_0000;
            run_op("rand", 5'($urandom_range(0, 22)), ra, rb, 5'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
